csr_bank: RTL
=============

Name: csr_bank

Overview:
- Parametrised control/status register bank; successor to the fixed 16-word single-port control RAM.
- Adds byte-enable writes, an explicit read-valid pulse and out-of-range error reporting.
- One register has sticky write-1-to-clear status semantics and one holds an interrupt mask.
- Sits between the core's memory-mapped control path and peripheral logic, and exposes all registers as flat outputs.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- NREG, 16: number of registers; power of two, 2..256.
- IDX_W, $clog2(NREG): register index width (derived).
- STAT_IDX, 1: index of the W1C status register.
- IEN_IDX, 2: index of the interrupt-enable register; must differ from STAT_IDX.

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  1  access request, one access per cycle, always accepted
- we  in  1  1 = write, 0 = read; sampled only when req=1
- be  in  DATA_W/8  byte enables for writes; bit i covers din[8i+7:8i]
- addr  in  32  word index (word-aligned address); addr[IDX_W-1:0] selects the register
- din  in  DATA_W  write data
- dout  out  DATA_W  read data, registered
- rvalid  out  1  one-cycle pulse when dout holds new read data
- err  out  1  one-cycle pulse for an out-of-range access
- hw_set  in  DATA_W  per-bit sticky set pulses into the status register
- irq  out  1  registered interrupt request
- regs  out  NREG*DATA_W  flat register contents; register k occupies bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset (rstn=0, asynchronous): all registers 0, dout=0, rvalid=0, err=0, irq=0. Reset asserted mid-access aborts the access; no write lands and no rvalid is issued.
- Range check: the access is out of range when addr[31:IDX_W] != 0. Then err=1 on the next cycle and no register changes. For an out-of-range read, rvalid=1 on the next cycle and dout=0.
- Read (req=1, we=0, in range): at edge N, dout <= reg[idx] and rvalid=1 during cycle N+1.
  - Latency is 1 cycle.
  - Read-first: the value is the one before any same-edge update.
  - dout holds its value until the next read; rvalid=0 when no read is issued.
- Write (req=1, we=1, in range): at edge N, each byte i with be[i]=1 is updated; bytes with be[i]=0 keep their value.
  - be=0 is a legal no-op.
  - No rvalid is issued for writes.
  - The write is visible on regs from cycle N+1.
- Ordinary registers (neither STAT_IDX nor IEN_IDX) are plain RW.
- IEN_IDX is plain RW.
- STAT_IDX is sticky W1C:
  - next = (cur & ~clr) | hw_set.
  - clr = din masked by the byte enables, when a write targets STAT_IDX; otherwise 0.
  - Writing 0 bits has no effect.
  - hw_set is sampled every cycle regardless of req.
  - If hw_set and a clear hit the same bit on the same edge, the set wins and the bit stays 1.
- A read of STAT_IDX on the same edge as hw_set returns the pre-set value; the new bit is visible on the next read.
- irq <= |(next_stat & ien_next), registered. irq therefore rises 1 cycle after the hw_set edge and falls 1 cycle after the clearing write or mask write.
- Back-to-back accesses every cycle are supported with no bubbles. A read on the cycle immediately after a write to the same index returns the written data.
- There is no backpressure; the block has no ready signal.

Test Plan:
- Reset, then read all indices 0..15 -> each read gives rvalid=1 one cycle later with dout=0; err stays 0.
- Write reg3 = 0xDEADBEEF with be=4'hF, then write din=0x11223344 with be=4'b0101 -> read reg3 returns 0xDE22BE44; regs[3*32 +: 32] matches from the cycle after each write.
- Pulse hw_set=0x0000_0005 for one cycle -> status=0x5 and irq=0. Then write ien=0x4 -> irq=1 on the following cycle. Then write status din=0x4 with be=4'hF -> status=0x1 and irq=0 on the following cycle.
- Same-edge conflict: hw_set=0x8 together with a status write din=0x8 while the bit is already 1 -> status bit3 stays 1.
- Out-of-range: read with addr=0x10, and write with addr=0x8000_0003 -> err pulses 1 cycle each, the read returns rvalid=1 with dout=0, and all regs are unchanged.
- Read-during-write and reset: same-edge read and write to reg5 is impossible on the single port, so cover back-to-back instead. Write reg5=0xA5, then read reg5 on the next cycle -> 0xA5. Assert rstn low between req and rvalid -> rvalid never pulses and all outputs are 0 immediately.

Source files
------------

// File: rtl/csr_bank.sv
// ---------------------------------------------------------------------------
// csr_bank
//   Parametrised control/status register bank sitting between the core's
//   memory-mapped control path and peripheral logic. It replaces the older
//   fixed 16-word control RAM and adds byte-enable writes, a read-valid
//   pulse and out-of-range error reporting.
//
//   Register STAT_IDX is a sticky status register. Hardware sets its bits
//   through hw_set, and software clears them by writing 1s (write-1-to-clear).
//   Register IEN_IDX is the interrupt mask. irq is the registered OR of
//   (status & mask).
//
// Parameters
//   DATA_W   register width in bits (multiple of 8)
//   NREG     number of registers (power of two, 2..256)
//   IDX_W    register index width, derived from NREG
//   STAT_IDX index of the W1C status register
//   IEN_IDX  index of the interrupt-enable register (differs from STAT_IDX)
//
// Ports
//   clk     in   clock, rising edge
//   rstn    in   asynchronous active-low reset
//   req     in   access request, accepted every cycle
//   we      in   1 = write, 0 = read
//   be      in   byte enables for writes
//   addr    in   word index; upper bits must be zero for an in-range access
//   din     in   write data
//   dout    out  registered read data, held until the next read
//   rvalid  out  one-cycle pulse when dout carries new read data
//   err     out  one-cycle pulse after an out-of-range access
//   hw_set  in   per-bit sticky set pulses into the status register
//   irq     out  registered interrupt request
//   regs    out  flat register contents, register k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module csr_bank #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 16,
  parameter int IDX_W    = $clog2(NREG),
  parameter int STAT_IDX = 1,
  parameter int IEN_IDX  = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req,
  input  logic                   we,
  input  logic [DATA_W/8-1:0]    be,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   rvalid,
  output logic                   err,
  input  logic [DATA_W-1:0]      hw_set,
  output logic                   irq,
  output logic [NREG*DATA_W-1:0] regs
);

  localparam int NBYTES = DATA_W / 8;

  // Register storage and output registers
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_dout;
  logic              r_rvalid;
  logic              r_err;
  logic              r_irq;

  // Decoded access
  logic              w_inRange;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_bmask;
  logic [DATA_W-1:0] w_clr;
  logic [DATA_W-1:0] w_next [NREG];
  logic [DATA_W-1:0] w_rdata;

  // Any address bit above the index field makes the access out of range.
  assign w_inRange = (addr[31:IDX_W] == '0);
  assign w_idx     = addr[IDX_W-1:0];
  assign w_wr      = req & we & w_inRange;
  assign w_rd      = req & ~we;

  // Expand the byte enables into a bit mask over the data word.
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w_bmask[8*i +: 8] = {8{be[i]}};
    end
  end

  // Clear mask for the status register: only the enabled 1-bits of din.
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_idx == IDX_W'(STAT_IDX))) begin
      w_clr = din & w_bmask;
    end
  end

  // Next-state value of every register. Plain registers merge the enabled
  // bytes; the status register applies W1C then ORs in hw_set, so a set on
  // the same edge as a clear leaves the bit at 1.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      w_next[k] = r_regs[k];
      if (k == STAT_IDX) begin
        w_next[k] = (r_regs[k] & ~w_clr) | hw_set;
      end else if (w_wr && (w_idx == IDX_W'(k))) begin
        w_next[k] = (r_regs[k] & ~w_bmask) | (din & w_bmask);
      end
    end
  end

  // Read data is taken from the current contents (read-first); an
  // out-of-range read returns zero.
  assign w_rdata = w_inRange ? r_regs[w_idx] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= w_next[k];
      end
    end
  end

  // Read port, error pulse and interrupt. irq looks at the post-edge values
  // so it follows the status/mask contents with one cycle of latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= req & ~w_inRange;
      r_irq    <= |(w_next[STAT_IDX] & w_next[IEN_IDX]);
      if (w_rd) begin
        r_dout <= w_rdata;
      end
    end
  end

  assign dout   = r_dout;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign irq    = r_irq;

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs[k*DATA_W +: DATA_W] = r_regs[k];
  end

endmodule
